// File: rtl/nn_layer_sched_if.sv
// MAC engine handshake bundle: restart strobe, neuron select and input count
// out of the scheduler, completion level and accumulation back into it.
interface nn_layer_sched_if #(
  parameter int ACC_W = 16
);
  logic             mac_reset;
  logic [4:0]       mac_neuron_no;
  logic [8:0]       mac_no_of_inputs;
  logic             mac_done;
  logic [ACC_W-1:0] mac_result;

  modport master (
    output mac_reset,
    output mac_neuron_no,
    output mac_no_of_inputs,
    input  mac_done,
    input  mac_result
  );

  modport slave (
    input  mac_reset,
    input  mac_neuron_no,
    input  mac_no_of_inputs,
    output mac_done,
    output mac_result
  );
endinterface

// File: rtl/nn_layer_sched.sv
// Layer scheduler: walks one shared MAC engine through every neuron of a layer,
// captures each accumulation into a result buffer and serves registered host reads.
module nn_layer_sched #(
  parameter int NUM_NEURONS = 25,
  parameter int NUM_INPUTS  = 400,
  parameter int ACC_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             layer_done,
  output logic             err,
  nn_layer_sched_if.master mac,
  output logic             res_valid,
  output logic [4:0]       res_idx,
  output logic [ACC_W-1:0] res_data,
  input  logic [4:0]       rd_addr,
  output logic [ACC_W-1:0] rd_data
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [4:0]      LAST_IDX = 5'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GUARD,
    WAIT,
    STORE,
    NEXT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [4:0]       idx;
  logic [CNT_W-1:0] wait_cnt;
  logic [ACC_W-1:0] buffer [NUM_NEURONS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // GUARD never looks at mac_done: the previous neuron's done level can still be high there.
  always_comb begin
    state_nxt            = state;
    busy                 = 1'b1;
    layer_done           = 1'b0;
    mac.mac_reset        = 1'b0;
    mac.mac_neuron_no    = idx;
    mac.mac_no_of_inputs = 9'(NUM_INPUTS);
    unique case (state)
      IDLE: begin
        busy          = 1'b0;
        mac.mac_reset = 1'b1;
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        mac.mac_reset = 1'b1;
        state_nxt     = GUARD;
      end
      GUARD: state_nxt = WAIT;
      WAIT: begin
        if (mac.mac_done) begin
          state_nxt = STORE;
        end else if (wait_cnt == CNT_MAX) begin
          state_nxt = DONE;
        end
      end
      STORE: state_nxt = NEXT;
      NEXT: state_nxt = (idx == LAST_IDX) ? DONE : ISSUE;
      DONE: begin
        layer_done    = 1'b1;
        mac.mac_reset = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The result is latched on the WAIT->STORE edge so res_valid/res_data line up with STORE.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      wait_cnt  <= '0;
      err       <= 1'b0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= 1'b0;
      if (state == IDLE && start) begin
        idx <= '0;
        err <= 1'b0;
      end
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
        if (mac.mac_done) begin
          res_valid <= 1'b1;
          res_idx   <= idx;
          res_data  <= mac.mac_result;
        end else if (wait_cnt == CNT_MAX) begin
          err <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
      if (state == NEXT && idx != LAST_IDX) begin
        idx <= idx + 5'd1;
      end
    end
  end

  // The buffer survives reset; it is written at the end of STORE so a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (!reset && state == STORE) begin
      buffer[res_idx] <= res_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (int'(rd_addr) < NUM_NEURONS) begin
      rd_data <= buffer[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: doc/nn_layer_sched.md
Name: nn_layer_sched

Overview:
Layer scheduler that time-shares one 400-input MAC neuron engine across all neurons of a hidden layer. On a host start it sequences the MAC through neuron indices 0..NUM_NEURONS-1. Each sequence step restarts the MAC with a new neuron number, waits for its done, and captures the 16-bit accumulation into an internal result buffer. The host reads the buffer once the layer completes. The block sits between the layer-level control FSM and the MAC datapath.

Parameters:
NUM_NEURONS, 25, neurons per layer (1..32)
NUM_INPUTS, 400, inputs per neuron driven to MAC no_of_inputs (1..511)
ACC_W, 16, MAC result / buffer word width
TIMEOUT_CYC, 4096, max cycles to wait for mac_done before abort (≥4)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
start  in  1  single-cycle request to run the layer; honoured only in IDLE
busy  out  1  high from the cycle after an accepted start until DONE exits
layer_done  out  1  one-cycle pulse in the DONE state
err  out  1  sticky timeout flag; cleared by reset or next accepted start
mac_reset  out  1  MAC restart strobe; high exactly one cycle per neuron
mac_neuron_no  out  5  neuron index presented to MAC; held stable through WAIT
mac_no_of_inputs  out  9  constant NUM_INPUTS
mac_done  in  1  MAC completion level
mac_result  in  ACC_W  MAC accumulation, valid while mac_done=1
res_valid  out  1  one-cycle pulse when a result is written to the buffer
res_idx  out  5  neuron index of the write (valid with res_valid)
res_data  out  ACC_W  written value (valid with res_valid)
rd_addr  in  5  host read address
rd_data  out  ACC_W  buffer[rd_addr], registered (1-cycle read latency)

Behaviour:
- Reset values: busy=0, layer_done=0, err=0, mac_reset=1 (MAC held idle), mac_neuron_no=0, res_valid=0, res_idx=0, res_data=0, rd_data=0, idx=0, wait counter=0. Buffer contents are not cleared.
- State encoding: IDLE, ISSUE, GUARD, WAIT, STORE, NEXT, DONE.
- IDLE: mac_reset=1. On start, go to ISSUE and set idx=0, err=0.
- ISSUE (1 cycle): mac_neuron_no=idx, mac_reset=1. Go to GUARD.
- GUARD (1 cycle): mac_reset=0. mac_done is ignored because the previous neuron's done may still be high. Go to WAIT.
- WAIT: increment the wait counter each cycle.
  - mac_done=1 → STORE.
  - Counter reaches TIMEOUT_CYC-1 without mac_done → set err, go to DONE. Remaining neurons are not processed; their buffer entries are unchanged.
- STORE (1 cycle): buffer[idx]=mac_result; res_valid=1, res_idx=idx, res_data=mac_result. Clear the wait counter.
- NEXT (1 cycle):
  - idx==NUM_NEURONS-1 → DONE.
  - Otherwise idx=idx+1 → ISSUE. idx never wraps.
- DONE (1 cycle): layer_done=1, mac_reset=1. Go to IDLE.
- busy=1 in every state except IDLE. Scheduler overhead per neuron is 5 cycles plus the MAC latency.
- start asserted outside IDLE is ignored and not queued. A start in the same cycle as the DONE→IDLE transition is also ignored.
- reset mid-layer: reset wins over all other inputs. FSM returns to IDLE next edge; no layer_done or res_valid is emitted.
- Buffer read: rd_data updates every cycle from the buffer.
  - rd_addr ≥ NUM_NEURONS returns 0.
  - A read and a STORE to the same address in the same cycle returns the old value.
- mac_result is captured unmodified; no saturation or sign handling in this block.
- mac_done high during WAIT for exactly one cycle is sufficient to advance.

Test Plan:
1. Normal layer: NUM_NEURONS=4, MAC model returns 16'h0100+n after 10 cycles → 4 res_valid pulses with idx 0..3 and data 0100..0103, one layer_done, busy for 4×15+1 cycles; rd_addr=2 then reads 16'h0102.
2. Stale done: MAC model keeps mac_done=1 through ISSUE/GUARD of the next neuron, then drops → result for neuron 1 is not captured until a new done; no duplicate res_valid.
3. Timeout: TIMEOUT_CYC=8, MAC never finishes neuron 2 → err=1, layer_done pulse, res_valid only for idx 0,1; the next start clears err.
4. Start while busy: pulse start during WAIT of neuron 1 → ignored; exactly NUM_NEURONS res_valid pulses and one layer_done.
5. Reset mid-operation: assert reset during WAIT of neuron 2 → next cycle busy=0, mac_reset=1, mac_neuron_no=0, no layer_done; a fresh start then runs from idx 0.
6. Read boundary: rd_addr=31 with NUM_NEURONS=25 → rd_data=0; a read of idx 3 in the same cycle as its STORE returns the previous contents.
